// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings, port ids and default timing for the two-port DRAM arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACC_RD = 2'd1,
      ST_ACC_WR = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LDR  = 1'b1;

   localparam int DEF_RD_LAT = 2;
   localparam int DEF_WR_CYC = 1;

   // Wide enough to hold the longest access length minus one without wrapping.
   function automatic int cnt_width(input int rd_lat, input int wr_cyc);
      int m;
      m = (rd_lat > wr_cyc) ? rd_lat : wr_cyc;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the port that did not win last time wins.
module rr_arb2 (
   input  logic       Req0,
   input  logic       Req1,
   input  logic       Last,
   output logic [1:0] Grant,
   output logic       GrantId
);

   always_comb begin
      GrantId = 1'b0;
      if (Req0 && Req1) begin
         GrantId = ~Last;
      end else if (Req1) begin
         GrantId = 1'b1;
      end
      Grant = {GrantId, ~GrantId} & {2{Req0 | Req1}};
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported DRAM between the core (port 0) and the loader/debug master (port 1).
// state     | meaning
// ST_IDLE   | no access in flight; requests are sampled only here
// ST_ACC_RD | RD held with latched address for RD_LAT cycles
// ST_ACC_WR | WR held with latched address/data for WR_CYC cycles
// ST_RESP   | one-cycle RValid pulse to the port that was served
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int WR_CYC = DEF_WR_CYC
) (
   input  logic          Clk1,
   input  logic          Reset,
   input  logic          Req0,
   input  logic          We0,
   input  logic [AW-1:0] Addr0,
   input  logic [DW-1:0] WData0,
   output logic          Ack0,
   output logic          RValid0,
   output logic [DW-1:0] RData0,
   input  logic          Req1,
   input  logic          We1,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData1,
   output logic          Ack1,
   output logic          RValid1,
   output logic [DW-1:0] RData1,
   output logic [AW-1:0] Addr,
   output logic          RD,
   output logic          WR,
   output logic [DW-1:0] DataOut,
   input  logic [DW-1:0] DataIn,
   output logic          Busy
);

   localparam int CW = cnt_width(RD_LAT, WR_CYC);
   localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);
   localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          port_q, port_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;

   logic [1:0]    grant;
   logic          grant_id;
   logic          acc_rd, acc_wr, acc_first;

   rr_arb2 u_rr_arb2 (
      .Req0    (Req0),
      .Req1    (Req1),
      .Last    (last_q),
      .Grant   (grant),
      .GrantId (grant_id)
   );

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         last_q   <= PORT_LDR;
         port_q   <= PORT_CORE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         port_q   <= port_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      port_d   = port_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               port_d  = grant_id;
               last_d  = grant_id;
               we_d    = grant_id ? We1 : We0;
               addr_d  = grant_id ? Addr1 : Addr0;
               wdata_d = grant_id ? WData1 : WData0;
               cnt_d   = '0;
               state_d = (grant_id ? We1 : We0) ? ST_ACC_WR : ST_ACC_RD;
            end
         end
         ST_ACC_RD: begin
            // DataIn is only guaranteed on the edge closing the last RD cycle.
            if (cnt_q == RD_LAST) begin
               cnt_d   = '0;
               state_d = ST_RESP;
               if (port_q == PORT_LDR) begin
                  rdata1_d = DataIn;
               end else begin
                  rdata0_d = DataIn;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_ACC_WR: begin
            if (cnt_q == WR_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign acc_rd    = (state_q == ST_ACC_RD);
   assign acc_wr    = (state_q == ST_ACC_WR);
   assign acc_first = (acc_rd || acc_wr) && (cnt_q == '0);

   assign RD      = acc_rd;
   assign WR      = acc_wr;
   assign Addr    = (acc_rd || acc_wr) ? addr_q : '0;
   assign DataOut = acc_wr ? wdata_q : '0;
   assign Busy    = (state_q != ST_IDLE);

   assign Ack0    = acc_first && (port_q == PORT_CORE);
   assign Ack1    = acc_first && (port_q == PORT_LDR);
   assign RValid0 = (state_q == ST_RESP) && (port_q == PORT_CORE);
   assign RValid1 = (state_q == ST_RESP) && (port_q == PORT_LDR);
   assign RData0  = rdata0_q;
   assign RData1  = rdata1_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single-ported 16-bit DRAM between the CVP14 core (port 0) and a loader/debug master (port 1).
- Sequences each DRAM access: drives Addr/RD/WR/DataOut, counts read latency, and returns read data to the winning port.
- Uses round-robin arbitration so neither port starves.

Parameters:
AW, 16, address width
DW, 16, data width
RD_LAT, 2, cycles RD is held before DataIn is valid; sampled on the edge ending the last RD cycle; min 1
WR_CYC, 1, cycles WR is held per write; min 1

Ports:
Clk1  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Req0  in  1  port 0 request; held with We0/Addr0/WData0 until Ack0
We0  in  1  port 0: 1=write, 0=read
Addr0  in  AW  port 0 address
WData0  in  DW  port 0 write data
Ack0  out  1  one-cycle pulse: port 0 request captured
RValid0  out  1  one-cycle pulse: RData0 valid
RData0  out  DW  port 0 read data; holds until next port 0 read completes
Req1, We1, Addr1, WData1, Ack1, RValid1, RData1  same as port 0, for port 1
Addr  out  AW  DRAM address
RD  out  1  DRAM read strobe
WR  out  1  DRAM write strobe
DataOut  out  DW  DRAM write data
DataIn  in  DW  DRAM read data
Busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, Last=1 (port 0 wins first), counter=0. All outputs are 0 after the reset edge, including RData0/1. A transaction in flight is abandoned and no RValid is produced.
- States: IDLE, ACC_RD, ACC_WR, RESP.
- IDLE, no request: stay in IDLE. Addr, DataOut, RD and WR are 0.
- IDLE, any ReqN at an edge:
  - Winner: if only one port requests, that port wins. If both request, the port != Last wins.
  - Latch the winner's id, We, Addr and WData. Set Last = winner.
  - Go to ACC_RD or ACC_WR. counter=0.
- Ack timing: AckN=1 during the first ACC cycle only, i.e. the cycle after capture.
  - Requests are sampled only in IDLE.
  - A requester keeping ReqN high after Ack issues a new request. It must present new Addr/We/WData on the Ack cycle.
- ACC_RD:
  - RD=1; Addr = latched address. Held for exactly RD_LAT cycles.
  - On the edge ending the last cycle, register DataIn into RDataN of the latched port. Go to RESP.
- RESP: RValidN=1 for one cycle. RD=0, Addr=0. Then go to IDLE.
- ACC_WR: WR=1; Addr and DataOut = latched values. Held for WR_CYC cycles, then go to IDLE.
- Throughput:
  - Read: capture edge at cycle 0, RD in cycles 1..RD_LAT, RValid in cycle RD_LAT+1. Next capture possible at the end of cycle RD_LAT+2. Period RD_LAT+2.
  - Write: period WR_CYC+1.
- Ordering: RD and WR are never high together. At most one access is outstanding.
- Counter width is clog2(max(RD_LAT,WR_CYC))+1 bits. It never wraps during an access.
- Reset asserted in any state takes priority over every transition.
- Ack/RValid/RData of the non-granted port do not change.

Decomposition:
- Shared include mem_arb_defs.vh holds:
  - state encodings ST_IDLE/ST_ACC_RD/ST_ACC_WR/ST_RESP
  - port ids PORT_CORE=0, PORT_LDR=1
  - default RD_LAT/WR_CYC
- One sub-module, rr_arb2: combinational two-way round-robin pick.
  - Inputs: Req0, Req1, Last.
  - Outputs: Grant (1-hot), GrantId.
- The FSM, latency counter and DRAM drive stay in the top module.

Test Plan:
- Read, RD_LAT=2, DRAM[0x0010]=0xBEEF; Req0=1, We0=0, Addr0=0x0010 at cycle 0 -> Ack0 in cycle 1; RD=1 and Addr=0x0010 in cycles 1-2; RValid0=1 and RData0=0xBEEF in cycle 3; Busy low in cycle 4.
- Write then read; Req1, We1=1, Addr1=0x0020, WData1=0x1234 -> WR=1 and DataOut=0x1234 for 1 cycle, Ack1 in the same cycle. A following port 1 read of 0x0020 returns RData1=0x1234.
- Contention: Req0 and Req1 held high continuously from reset with reads -> grants go 0,1,0,1; Ack pulses spaced 4 cycles apart; RValid only on the granted port.
- Reset mid-access: assert Reset during the first RD cycle of a port 1 read -> after the edge RD=0, Busy=0, no RValid1, RData1=0. After release, simultaneous requests grant port 0 first.
- Idle neighbour: Req1=0, port 0 issues 3 back-to-back reads -> Ack0 every RD_LAT+2=4 cycles, with no bubble for port 1. Addr=0 in each RESP cycle.
- Parameter sweep: RD_LAT=1 and RD_LAT=4 -> RD high 1 and 4 cycles respectively; RValid exactly one cycle after RD falls.
